// File: rtl/uart_tx_ctrl.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop
// frame sequencer with a fixed bit period and a registered serial output.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_valid_i,
    input  logic [7:0]         wr_data_i,
    output logic               wr_ready_o,
    input  logic               tx_en_i,
    output logic [FIFO_AW:0]   level_o,
    output logic               empty_o,
    output logic               busy_o,
    output logic               uart_tx_o
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned BaudW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [FIFO_AW:0] FullCount = (FIFO_AW + 1)'(Depth);
    localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    // Frame sequencer
    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               baud_last;

    assign full       = (count_q == FullCount);
    assign empty      = (count_q == '0);
    assign push       = wr_valid_i && !full;
    assign head       = mem_q[rd_ptr_q];
    assign baud_last  = (baud_q == BaudLast);

    assign wr_ready_o = !full;
    assign level_o    = count_q;
    assign empty_o    = empty;
    assign busy_o     = (state_q != StIdle);
    assign uart_tx_o  = tx_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // tx_d is computed for the state being entered so the line changes on the
    // same edge as the state and stays a clean register output.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (tx_en_i && !empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (tx_en_i && !empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at 4 clocks per bit and a 4-entry FIFO.
module tb_uart_tx_ctrl;

    localparam int unsigned Cpb = 4;
    localparam int unsigned Aw  = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          wr_valid_i;
    logic [7:0]    wr_data_i;
    logic          wr_ready_o;
    logic          tx_en_i;
    logic [Aw:0]   level_o;
    logic          empty_o;
    logic          busy_o;
    logic          uart_tx_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT (Cpb),
        .FIFO_AW      (Aw)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .tx_en_i    (tx_en_i),
        .level_o    (level_o),
        .empty_o    (empty_o),
        .busy_o     (busy_o),
        .uart_tx_o  (uart_tx_o)
    );

    // Expected line level c cycles into a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int c);
        int slot;
        slot = c / Cpb;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; wr_valid_i = 1'b0; wr_data_i = 8'h00; tx_en_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (uart_tx_o !== 1'b1 || wr_ready_o !== 1'b1 || level_o !== 3'd0 ||
                busy_o !== 1'b0 || empty_o !== 1'b1) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got tx=%b rdy=%b lvl=%0d busy=%b empty=%b want 1 1 0 0 1",
                         i, uart_tx_o, wr_ready_o, level_o, busy_o, empty_o);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        b = 8'hA5;
        tx_en_i = 1'b1;
        wr_valid_i = 1'b1; wr_data_i = b;
        tick();
        wr_valid_i = 1'b0;
        total++;
        if (level_o !== 3'd1 || uart_tx_o !== 1'b1) begin
            bad++;
            $display("FAIL single_accept got lvl=%0d tx=%b want lvl=1 tx=1", level_o, uart_tx_o);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            total++;
            if (uart_tx_o !== frame_bit(b, c) || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL single_frame c=%0d got tx=%b busy=%b want tx=%b busy=1",
                         c, uart_tx_o, busy_o, frame_bit(b, c));
            end
        end
        tick();
        total++;
        if (busy_o !== 1'b0 || uart_tx_o !== 1'b1 || level_o !== 3'd0) begin
            bad++;
            $display("FAIL single_end got busy=%b tx=%b lvl=%0d want 0 1 0", busy_o, uart_tx_o, level_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int peak;
        int f;
        int c;
        bytes[0] = 8'h55; bytes[1] = 8'h0F; bytes[2] = 8'hFF;
        tx_en_i = 1'b1;
        wr_valid_i = 1'b1; wr_data_i = bytes[0];
        tick();
        peak = int'(level_o);
        for (int t = 1; t <= 120; t++) begin
            if (t == 1) wr_data_i = bytes[1];
            else if (t == 2) wr_data_i = bytes[2];
            else wr_valid_i = 1'b0;
            tick();
            if (int'(level_o) > peak) peak = int'(level_o);
            f = (t - 1) / 40;
            c = (t - 1) % 40;
            total++;
            if (uart_tx_o !== frame_bit(bytes[f], c) || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL b2b_frame t=%0d got tx=%b busy=%b want tx=%b busy=1",
                         t, uart_tx_o, busy_o, frame_bit(bytes[f], c));
            end
        end
        total++;
        if (peak != 2) begin
            bad++;
            $display("FAIL b2b_peak got %0d want 2", peak);
        end
        tick();
        total++;
        if (busy_o !== 1'b0 || level_o !== 3'd0 || uart_tx_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_end got busy=%b lvl=%0d tx=%b want 0 0 1", busy_o, level_o, uart_tx_o);
        end
    endtask

    task automatic test_full();
        logic [7:0] bytes [5];
        int want_lvl;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h99;
        tx_en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid_i = 1'b1; wr_data_i = bytes[i];
            tick();
            want_lvl = (i < 4) ? i + 1 : 4;
            total++;
            if (int'(level_o) != want_lvl || wr_ready_o !== (want_lvl < 4) ||
                busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
                bad++;
                $display("FAIL full_push i=%0d got lvl=%0d rdy=%b busy=%b tx=%b want lvl=%0d rdy=%b busy=0 tx=1",
                         i, level_o, wr_ready_o, busy_o, uart_tx_o, want_lvl, want_lvl < 4);
            end
        end
        wr_valid_i = 1'b0;
        tx_en_i = 1'b1;
        for (int t = 1; t <= 160; t++) begin
            tick();
            total++;
            if (uart_tx_o !== frame_bit(bytes[(t-1)/40], (t-1) % 40)) begin
                bad++;
                $display("FAIL full_frames t=%0d got tx=%b want %b",
                         t, uart_tx_o, frame_bit(bytes[(t-1)/40], (t-1) % 40));
            end
            if (t == 1) begin
                total++;
                if (level_o !== 3'd3 || wr_ready_o !== 1'b1) begin
                    bad++;
                    $display("FAIL full_first_pop got lvl=%0d rdy=%b want 3 1", level_o, wr_ready_o);
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (uart_tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 3'd0) begin
                bad++;
                $display("FAIL full_no_fifth i=%0d got tx=%b busy=%b lvl=%0d want 1 0 0",
                         i, uart_tx_o, busy_o, level_o);
            end
        end
    endtask

    task automatic test_disable();
        logic [7:0] bytes [3];
        bytes[0] = 8'h3C; bytes[1] = 8'h81; bytes[2] = 8'h7E;
        tx_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid_i = 1'b1; wr_data_i = bytes[i];
            tick();
        end
        wr_valid_i = 1'b0;
        tx_en_i = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            if (t == 10) tx_en_i = 1'b0;
            tick();
            total++;
            if (uart_tx_o !== frame_bit(bytes[0], t - 1) || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL dis_frame1 t=%0d got tx=%b busy=%b want tx=%b busy=1",
                         t, uart_tx_o, busy_o, frame_bit(bytes[0], t - 1));
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (uart_tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 3'd2) begin
                bad++;
                $display("FAIL dis_hold i=%0d got tx=%b busy=%b lvl=%0d want 1 0 2",
                         i, uart_tx_o, busy_o, level_o);
            end
        end
        tx_en_i = 1'b1;
        for (int t = 1; t <= 80; t++) begin
            tick();
            total++;
            if (uart_tx_o !== frame_bit(bytes[1 + (t-1)/40], (t-1) % 40)) begin
                bad++;
                $display("FAIL dis_resume t=%0d got tx=%b want %b",
                         t, uart_tx_o, frame_bit(bytes[1 + (t-1)/40], (t-1) % 40));
            end
        end
        tick();
        total++;
        if (busy_o !== 1'b0 || level_o !== 3'd0) begin
            bad++;
            $display("FAIL dis_end got busy=%b lvl=%0d want 0 0", busy_o, level_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        tx_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid_i = 1'b1; wr_data_i = bytes[i];
            tick();
        end
        wr_valid_i = 1'b0;
        tx_en_i = 1'b1;
        // Run into data bit 3 (frame cycles 16..19) before resetting.
        for (int t = 1; t <= 17; t++) begin
            tick();
            total++;
            if (uart_tx_o !== frame_bit(bytes[0], t - 1)) begin
                bad++;
                $display("FAIL rst_pre t=%0d got tx=%b want %b", t, uart_tx_o, frame_bit(bytes[0], t - 1));
            end
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++;
        if (uart_tx_o !== 1'b1 || level_o !== 3'd0 || busy_o !== 1'b0 ||
            empty_o !== 1'b1 || wr_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid got tx=%b lvl=%0d busy=%b empty=%b rdy=%b want 1 0 0 1 1",
                     uart_tx_o, level_o, busy_o, empty_o, wr_ready_o);
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            total++;
            if (uart_tx_o !== 1'b1 || level_o !== 3'd0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL rst_after i=%0d got tx=%b lvl=%0d busy=%b want 1 0 0",
                         i, uart_tx_o, level_o, busy_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_disable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
